// File: rtl/adc_sample_conditioner_pkg.sv
// Shared constants and types for the ADC sample conditioning front end.
package adc_sample_conditioner_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 10;
  localparam int unsigned DEF_WINDOW_LOG2 = 16;
  localparam int unsigned DEF_MIDPOINT    = 512;
  localparam int unsigned DEF_TEST_MAX    = 1020;
  localparam int unsigned WORD_WIDTH      = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

endpackage

// File: rtl/adc_sample_conditioner_offset_estimator.sv
// Windowed mean estimator: reports (window mean - MIDPOINT) after every full window.
module offset_estimator
  import adc_sample_conditioner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int unsigned MIDPOINT    = DEF_MIDPOINT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [DATA_WIDTH-1:0]        sample,
  output logic signed [DATA_WIDTH:0]   offset,
  output logic                         offset_valid
);

  localparam int unsigned ACC_WIDTH = DATA_WIDTH + WINDOW_LOG2;
  localparam logic signed [DATA_WIDTH:0] MID = (DATA_WIDTH + 1)'(MIDPOINT);

  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [WINDOW_LOG2-1:0] count;
  logic [DATA_WIDTH-1:0]  mean;
  logic                   window_done;

  // The mean includes the sample arriving on the closing cycle of the window.
  always_comb begin
    acc_sum     = acc + ACC_WIDTH'(sample);
    mean        = acc_sum[ACC_WIDTH-1:WINDOW_LOG2];
    window_done = (count == '1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      count        <= '0;
      offset       <= '0;
      offset_valid <= 1'b0;
    end else if (!enable) begin
      acc   <= '0;
      count <= '0;
    end else if (window_done) begin
      acc          <= '0;
      count        <= '0;
      offset       <= $signed({1'b0, mean}) - MID;
      offset_valid <= 1'b1;
    end else begin
      acc   <= acc_sum;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adc_sample_conditioner.sv
// ADC front end: collect synchroniser, capture FSM, two-stage sample pipeline,
// test ramp and clamped DC-offset compensation.
module adc_sample_conditioner
  import adc_sample_conditioner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int unsigned MIDPOINT    = DEF_MIDPOINT,
  parameter int unsigned TEST_MAX    = DEF_TEST_MAX
) (
  input  logic                        adc_clock,
  input  logic                        reset,
  input  logic                        collectData,
  input  logic                        testMode,
  input  logic                        dcOffsetComp,
  input  logic [DATA_WIDTH-1:0]       adcData,
  output logic [WORD_WIDTH-1:0]       sampleOut,
  output logic                        sampleValid,
  output logic signed [DATA_WIDTH:0]  currentOffset,
  output logic                        offsetValid
);

  state_t                       state;
  logic                         collect_meta;
  logic                         collect_s;
  logic                         capturing;
  logic [DATA_WIDTH-1:0]        raw;
  logic [DATA_WIDTH-1:0]        ramp;
  logic [DATA_WIDTH-1:0]        comp_code;
  logic [DATA_WIDTH-1:0]        cond;
  logic signed [DATA_WIDTH+1:0] diff;

  assign capturing = (state == CAPTURE);

  always_ff @(posedge adc_clock) begin
    if (reset) begin
      collect_meta <= 1'b0;
      collect_s    <= 1'b0;
    end else begin
      collect_meta <= collectData;
      collect_s    <= collect_meta;
    end
  end

  always_ff @(posedge adc_clock) begin
    if (reset) begin
      state       <= IDLE;
      sampleValid <= 1'b0;
    end else begin
      sampleValid <= capturing;
      case (state)
        IDLE:    if (collect_s)  state <= CAPTURE;
        CAPTURE: if (!collect_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Two extra bits keep raw - offset exact; the top bits flag underflow/overflow.
  always_comb begin
    diff = $signed({2'b00, raw}) - $signed({currentOffset[DATA_WIDTH], currentOffset});
    if (diff[DATA_WIDTH+1]) begin
      comp_code = '0;
    end else if (diff[DATA_WIDTH]) begin
      comp_code = '1;
    end else begin
      comp_code = diff[DATA_WIDTH-1:0];
    end

    if (testMode) begin
      cond = ramp;
    end else if (dcOffsetComp && offsetValid) begin
      cond = comp_code;
    end else begin
      cond = raw;
    end
  end

  always_ff @(posedge adc_clock) begin
    if (reset) begin
      raw       <= '0;
      sampleOut <= '0;
      ramp      <= '0;
    end else begin
      raw <= adcData;
      if (capturing) begin
        sampleOut <= WORD_WIDTH'(cond);
      end
      if (!testMode) begin
        ramp <= '0;
      end else if (capturing) begin
        ramp <= (ramp == DATA_WIDTH'(TEST_MAX)) ? '0 : ramp + 1'b1;
      end
    end
  end

  offset_estimator #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WINDOW_LOG2 (WINDOW_LOG2),
    .MIDPOINT    (MIDPOINT)
  ) u_offset_estimator (
    .clk          (adc_clock),
    .reset        (reset),
    .enable       (capturing && !testMode),
    .sample       (raw),
    .offset       (currentOffset),
    .offset_valid (offsetValid)
  );

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed/random bench for adc_sample_conditioner with a window of 16 samples.
module tb_adc_sample_conditioner;

  localparam int WLOG2    = 4;
  localparam int WINDOW   = 1 << WLOG2;
  localparam int MIDPOINT = 512;
  localparam int TEST_MAX = 1020;
  localparam int CODE_MAX = 1023;

  logic               adc_clock = 1'b0;
  logic               reset;
  logic               collectData;
  logic               testMode;
  logic               dcOffsetComp;
  logic [9:0]         adcData;
  logic [15:0]        sampleOut;
  logic               sampleValid;
  logic signed [10:0] currentOffset;
  logic               offsetValid;

  int tests = 0;
  int fails = 0;

  // Behavioural reference state
  int m_raw, m_out, m_off, m_ramp;
  bit m_valid, m_offv;
  bit hist [3];
  int win [$];

  always #5 adc_clock = ~adc_clock;

  adc_sample_conditioner #(
    .WINDOW_LOG2 (WLOG2)
  ) dut (
    .adc_clock     (adc_clock),
    .reset         (reset),
    .collectData   (collectData),
    .testMode      (testMode),
    .dcOffsetComp  (dcOffsetComp),
    .adcData       (adcData),
    .sampleOut     (sampleOut),
    .sampleValid   (sampleValid),
    .currentOffset (currentOffset),
    .offsetValid   (offsetValid)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: a word leaves 3 edges after collect is seen, carrying the sample taken one edge earlier.
  task automatic model_edge();
    bit cap;
    int v;
    if (reset) begin
      m_raw = 0; m_out = 0; m_off = 0; m_ramp = 0;
      m_valid = 0; m_offv = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
      win.delete();
    end else begin
      cap = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = collectData;
      m_valid = cap;
      if (cap) begin
        if (testMode) begin
          m_out  = m_ramp;
          m_ramp = (m_ramp == TEST_MAX) ? 0 : m_ramp + 1;
        end else if (dcOffsetComp && m_offv) begin
          v = m_raw - m_off;
          if (v < 0) v = 0;
          if (v > CODE_MAX) v = CODE_MAX;
          m_out = v;
        end else begin
          m_out = m_raw;
        end
      end
      if (!testMode) m_ramp = 0;
      if (cap && !testMode) begin
        win.push_back(m_raw);
        if (win.size() == WINDOW) begin
          m_off  = win.sum() / WINDOW - MIDPOINT;
          m_offv = 1;
          win.delete();
        end
      end else begin
        win.delete();
      end
      m_raw = int'(adcData);
    end
  endtask

  task automatic cycle();
    @(posedge adc_clock);
    model_edge();
    #1;
    check("valid",      sampleValid,   int'(m_valid));
    check("sample",     sampleOut,     m_out);
    check("offset",     currentOffset, m_off);
    check("offset_vld", offsetValid,   int'(m_offv));
    @(negedge adc_clock);
  endtask

  task automatic idle(input int n);
    collectData = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; collectData = 1'b1; testMode = 1'b0; dcOffsetComp = 1'b0;
    adcData = 10'h3FF;

    // Reset with collect and full-scale ADC present
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_out",   sampleOut,     0);
      check("rst_valid", sampleValid,   0);
      check("rst_off",   currentOffset, 0);
      check("rst_offv",  offsetValid,   0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("sync_valid_low", sampleValid, 0);
    end

    // Pass-through, 2-cycle latency
    for (int i = 0; i < 14; i++) begin
      adcData = (i < 10) ? 10'(i) : 10'($urandom_range(0, 1023));
      cycle();
      if (i == 0) check("first_valid", sampleValid, 1);
      if (i >= 1 && i <= 10) check("pass", sampleOut, i - 1);
    end
    idle(6);

    // Offset estimation on a constant 600
    adcData = 10'd600; collectData = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    check("est_offset", currentOffset, 88);
    check("est_valid",  offsetValid,   1);
    dcOffsetComp = 1'b1;
    cycle();
    check("comp_mid", sampleOut, 512);
    for (int i = 0; i < 4; i++) cycle();
    idle(6);

    // Clamp low: 50 - 88
    adcData = 10'd50; collectData = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("clamp_lo_valid", sampleValid, 1);
    check("clamp_lo",       sampleOut,   0);
    adcData = 10'd312;
    idle(6);

    // Window of 312 then clamp high: 1000 + 200
    collectData = 1'b1;
    for (int i = 0; i < 22; i++) cycle();
    check("neg_offset", currentOffset, -200);
    adcData = 10'd1000;
    for (int i = 0; i < 2; i++) cycle();
    check("clamp_hi",     sampleOut,     1023);
    check("clamp_hi_off", currentOffset, -200);
    idle(6);

    // Test ramp with random ADC data, full wrap
    testMode = 1'b1; collectData = 1'b1;
    for (int i = 0; i < 1026; i++) begin
      adcData = 10'($urandom_range(0, 1023));
      cycle();
      if (i == 3)    check("ramp_first", sampleOut, 0);
      if (i == 1023) check("ramp_max",   sampleOut, TEST_MAX);
      if (i == 1024) check("ramp_wrap",  sampleOut, 0);
    end
    check("ramp_last",     sampleOut,     1);
    check("test_off_kept", currentOffset, -200);
    check("test_offv",     offsetValid,   1);
    idle(6);
    testMode = 1'b0;
    for (int i = 0; i < 2; i++) cycle();

    // Window abort after 10 samples, then fresh window of 400
    dcOffsetComp = 1'b0;
    adcData = 10'd700; collectData = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    adcData = 10'd400;
    idle(6);
    collectData = 1'b1;
    for (int i = 0; i < 18; i++) cycle();
    check("abort_kept", currentOffset, -200);
    cycle();
    check("abort_new",  currentOffset, -112);
    for (int i = 0; i < 5; i++) begin
      adcData = 10'($urandom_range(0, 1023));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
